// File: rtl/universal_register_pkg.sv
// Shared constants for the universal register: mode encodings and the
// per-bit next-state select used by the slice cells.
package universal_register_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_INC  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_DEC  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_CLR  = 3'b111;

    // LOWER takes the bit from the next less-significant position (left shift),
    // UPPER takes it from the next more-significant position (right shift).
    typedef enum logic [1:0] {
        SEL_HOLD  = 2'b00,
        SEL_LOAD  = 2'b01,
        SEL_LOWER = 2'b10,
        SEL_UPPER = 2'b11
    } slice_sel_e;

endpackage

// File: rtl/universal_register_if.sv
// Bus-side signal bundle of the universal register; the controller drives
// the mode/data side, the register drives the result side.
interface universal_register_if
    import universal_register_pkg::*;
#(
    parameter int WIDTH = 8
) ();

    logic [MODE_W-1:0] i_mode;
    logic [WIDTH-1:0]  i_data;
    logic              i_serial;
    logic              i_out_en;
    logic [WIDTH-1:0]  o_q;
    logic [WIDTH-1:0]  o_not_q;
    logic [WIDTH-1:0]  o_bus;
    logic              o_carry;
    logic              o_zero;

    modport master (
        output i_mode, i_data, i_serial, i_out_en,
        input  o_q, o_not_q, o_bus, o_carry, o_zero
    );

    modport slave (
        input  i_mode, i_data, i_serial, i_out_en,
        output o_q, o_not_q, o_bus, o_carry, o_zero
    );

endinterface

// File: rtl/universal_register_slice.sv
// One bit of the universal register: a 4:1 next-state mux feeding a
// synchronously reset D flip-flop.
module universal_register_slice
    import universal_register_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  slice_sel_e sel,
    input  logic       load_bit,
    input  logic       lower_bit,
    input  logic       upper_bit,
    output logic       q
);

    logic d;

    always_comb begin
        d = q;
        case (sel)
            SEL_HOLD:  d = q;
            SEL_LOAD:  d = load_bit;
            SEL_LOWER: d = lower_bit;
            SEL_UPPER: d = upper_bit;
            default:   d = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_BIT;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/universal_register.sv
// WIDTH-bit universal register with hold/load/shift/rotate/count/clear modes,
// carry and zero flags, and a gated (non-tristate) bus output.
module universal_register
    import universal_register_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    universal_register_if.slave  bus
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] load_vec;
    logic [WIDTH-1:0] lower_vec;
    logic [WIDTH-1:0] upper_vec;
    logic [WIDTH:0]   inc_sum;
    logic [WIDTH:0]   dec_diff;
    logic             lsb_in;
    logic             msb_in;
    logic             carry;
    logic             carry_next;
    slice_sel_e       slice_sel;

    // The extra top bit of each result is the wrap/borrow flag.
    assign inc_sum  = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_diff = {1'b0, q} - {{WIDTH{1'b0}}, 1'b1};

    assign lower_vec = {q[WIDTH-2:0], lsb_in};
    assign upper_vec = {msb_in, q[WIDTH-1:1]};

    // Arithmetic and clear reuse the slice load path; an unknown mode falls to hold.
    always_comb begin
        slice_sel  = SEL_HOLD;
        load_vec   = bus.i_data;
        lsb_in     = bus.i_serial;
        msb_in     = bus.i_serial;
        carry_next = carry;
        case (bus.i_mode)
            MODE_LOAD: begin
                slice_sel = SEL_LOAD;
            end
            MODE_SHL: begin
                slice_sel  = SEL_LOWER;
                carry_next = q[WIDTH-1];
            end
            MODE_SHR: begin
                slice_sel  = SEL_UPPER;
                carry_next = q[0];
            end
            MODE_ROL: begin
                slice_sel  = SEL_LOWER;
                lsb_in     = q[WIDTH-1];
                carry_next = q[WIDTH-1];
            end
            MODE_INC: begin
                slice_sel  = SEL_LOAD;
                load_vec   = inc_sum[WIDTH-1:0];
                carry_next = inc_sum[WIDTH];
            end
            MODE_DEC: begin
                slice_sel  = SEL_LOAD;
                load_vec   = dec_diff[WIDTH-1:0];
                carry_next = dec_diff[WIDTH];
            end
            MODE_CLR: begin
                slice_sel  = SEL_LOAD;
                load_vec   = '0;
                carry_next = 1'b0;
            end
            default: begin
                slice_sel = SEL_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carry <= 1'b0;
        end else begin
            carry <= carry_next;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        universal_register_slice #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_slice (
            .clk       (clk),
            .rst       (rst),
            .sel       (slice_sel),
            .load_bit  (load_vec[i]),
            .lower_bit (lower_vec[i]),
            .upper_bit (upper_vec[i]),
            .q         (q[i])
        );
    end

    assign bus.o_q     = q;
    assign bus.o_not_q = ~q;
    assign bus.o_bus   = bus.i_out_en ? q : '0;
    assign bus.o_carry = carry;
    assign bus.o_zero  = (q == '0);

endmodule

// File: tb/tb_universal_register.sv
// Scoreboard bench for universal_register: two instances (reset values 00 and 3C)
// share one stimulus stream and are compared against a behavioural model each edge.
module tb_universal_register;
    import universal_register_pkg::*;

    typedef struct {
        logic [7:0] qA;
        logic       cA;
        logic [7:0] qB;
        logic       cB;
        logic       outEn;
    } expect_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] mode;
    logic [7:0] data;
    logic       serial;
    logic       outEn;

    logic [7:0] modelQA, modelQB;
    logic       modelCA, modelCB;
    expect_t    sb[$];
    int         checks = 0;
    int         errors = 0;

    universal_register_if #(.WIDTH(8)) ifA ();
    universal_register_if #(.WIDTH(8)) ifB ();

    assign ifA.i_mode   = mode;
    assign ifA.i_data   = data;
    assign ifA.i_serial = serial;
    assign ifA.i_out_en = outEn;
    assign ifB.i_mode   = mode;
    assign ifB.i_data   = data;
    assign ifB.i_serial = serial;
    assign ifB.i_out_en = outEn;

    universal_register #(.WIDTH(8), .RESET_VALUE(8'h00)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (ifA)
    );

    universal_register #(.WIDTH(8), .RESET_VALUE(8'h3C)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (ifB)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference behaviour written straight from the mode table.
    task automatic modelStep(input logic r, input logic [2:0] m, input logic [7:0] d,
                             input logic s, input logic [7:0] rv,
                             inout logic [7:0] q, inout logic c);
        logic [7:0] nq;
        logic       nc;
        nq = q;
        nc = c;
        if (r) begin
            nq = rv;
            nc = 1'b0;
        end else begin
            case (m)
                MODE_LOAD: nq = d;
                MODE_SHL:  begin nq = {q[6:0], s};    nc = q[7]; end
                MODE_SHR:  begin nq = {s, q[7:1]};    nc = q[0]; end
                MODE_ROL:  begin nq = {q[6:0], q[7]}; nc = q[7]; end
                MODE_INC:  begin nq = (q == 8'hFF) ? 8'h00 : q + 8'd1; nc = (q == 8'hFF); end
                MODE_DEC:  begin nq = (q == 8'h00) ? 8'hFF : q - 8'd1; nc = (q == 8'h00); end
                MODE_CLR:  begin nq = 8'h00; nc = 1'b0; end
                default:   nq = q;
            endcase
        end
        q = nq;
        c = nc;
    endtask

    task automatic applyStimulus(input logic r, input logic [2:0] m, input logic [7:0] d,
                                 input logic s, input logic oe);
        expect_t e;
        @(negedge clk);
        rst    = r;
        mode   = m;
        data   = d;
        serial = s;
        outEn  = oe;
        if (!r && $isunknown(m)) checkOutput("modeKnown", 8'h01, 8'h00);
        modelStep(r, m, d, s, 8'h00, modelQA, modelCA);
        modelStep(r, m, d, s, 8'h3C, modelQB, modelCB);
        sb.push_back('{modelQA, modelCA, modelQB, modelCB, oe});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checkOutput("qA",     ifA.o_q, e.qA);
        checkOutput("notQA",  ifA.o_not_q, ~e.qA);
        checkOutput("zeroA",  {7'd0, ifA.o_zero}, {7'd0, (e.qA == 8'h00)});
        checkOutput("carryA", {7'd0, ifA.o_carry}, {7'd0, e.cA});
        checkOutput("busA",   ifA.o_bus, e.outEn ? e.qA : 8'h00);
        checkOutput("qB",     ifB.o_q, e.qB);
        checkOutput("carryB", {7'd0, ifB.o_carry}, {7'd0, e.cB});
        checkOutput("busB",   ifB.o_bus, e.outEn ? e.qB : 8'h00);
    endtask

    initial begin
        rst = 1'b1; mode = MODE_HOLD; data = 8'h00; serial = 1'b0; outEn = 1'b0;
        modelQA = 8'h00; modelCA = 1'b0; modelQB = 8'h3C; modelCB = 1'b0;

        // reset beats a pending LOAD
        applyStimulus(1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0);

        // load then hold with bus enable toggling
        applyStimulus(1'b0, MODE_LOAD, 8'hA5, 1'b0, 1'b1);
        applyStimulus(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0);

        // shift and rotate
        applyStimulus(1'b0, MODE_LOAD, 8'h81, 1'b0, 1'b1);
        applyStimulus(1'b0, MODE_SHL,  8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, MODE_SHR,  8'h00, 1'b1, 1'b1);
        applyStimulus(1'b0, MODE_ROL,  8'h00, 1'b0, 1'b1);

        // count across the wrap boundary both ways
        applyStimulus(1'b0, MODE_LOAD, 8'hFE, 1'b0, 1'b1);
        applyStimulus(1'b0, MODE_INC,  8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, MODE_INC,  8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, MODE_DEC,  8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, MODE_DEC,  8'h00, 1'b0, 1'b1);

        // reset in the middle of counting discards that edge's increment
        applyStimulus(1'b0, MODE_CLR,  8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, MODE_INC,  8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, MODE_INC,  8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, MODE_INC,  8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, MODE_INC,  8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, MODE_INC,  8'h00, 1'b0, 1'b0);

        // clear after load
        applyStimulus(1'b0, MODE_LOAD, 8'h55, 1'b0, 1'b1);
        applyStimulus(1'b0, MODE_CLR,  8'h00, 1'b0, 1'b1);

        // loopback load of the current bus value keeps the contents
        applyStimulus(1'b0, MODE_LOAD, 8'h3A, 1'b0, 1'b1);
        applyStimulus(1'b0, MODE_LOAD, ifA.o_bus, 1'b0, 1'b1);

        for (int i = 0; i < 60; i++) begin
            applyStimulus(($urandom_range(0, 15) == 0),
                          3'($urandom_range(0, 7)),
                          8'($urandom),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
